// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery parameter generator and reduction stage.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package mont_pkg;

    // Default datapath width; must be a power of 2 between 8 and 32.
    localparam int W_DEF = 32;

    // Width of the used-bits count (holds 0..32).
    localparam int NB = 6;

    // Sequencer states; encoding is visible to the bus wrapper's debug view.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INV_A = 3'd1,
        ST_INV_B = 3'd2,
        ST_R2    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Newton iterations needed: starting from 3 correct bits and doubling each
    // pass, 3*2^ni must cover w bits.
    function automatic int ni_of(input int w);
        return $clog2(w) - 1;
    endfunction

endpackage

// File: rtl/mont_lead_one.sv
// Used-bits detector: leading-one position + 1, or 0 for an all-zero input.
// Latency: purely combinational.
// Backpressure: none.
module mont_lead_one
    import mont_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]  val,
    output logic [NB-1:0] n_used
);

    // Scan upward; the highest set bit is the last one to overwrite the count.
    always_comb begin
        n_used = '0;
        for (int i = 0; i < W; i++) begin
            if (val[i]) begin
                n_used = NB'(i + 1);
            end
        end
    end

endmodule

// File: rtl/mont_param_gen.sv
// Computes -m^-1 mod 2^W, used bits n, and 2^(2n) mod m for an odd modulus m.
// Latency: done 2*NI + 2*n edges after the start edge; even m flags err on the start edge.
// Backpressure: start is ignored while busy; results are held until the next done.
module mont_param_gen
    import mont_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  m,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  m_inv,
    output logic [W-1:0]  r2,
    output logic [NB-1:0] n_bits
);

    localparam int NI = ni_of(W);
    // Doubling counter holds 2*n, at most 64.
    localparam int CW = NB + 1;
    localparam int IW = 3;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    m_q;
    logic [NB-1:0]   n_q;
    logic [W-1:0]    x;
    logic [W-1:0]    t;
    logic [W-1:0]    v;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   it;

    logic [NB-1:0]   n_in;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [W-1:0]    prod;
    logic [W:0]      d;
    logic [W:0]      d_sub;
    logic [W:0]      m_ext;
    logic [W-1:0]    v_nxt;
    logic            last_iter;
    logic            last_step;

    mont_lead_one #(.W(W)) u_lead_one (
        .val    (m),
        .n_used (n_in)
    );

    // One shared multiplier: INV_A forms t = m*x, INV_B forms x*(2 - t).
    always_comb begin
        mul_a = x;
        mul_b = W'(2) - t;
        if (state == ST_INV_A) begin
            mul_a = m_q;
            mul_b = x;
        end
        prod = mul_a * mul_b;
    end

    // Modular doubling step; v < m_q keeps 2v within W+1 bits and one subtract enough.
    always_comb begin
        d     = {v, 1'b0};
        m_ext = {1'b0, m_q};
        d_sub = d - m_ext;
        v_nxt = (d >= m_ext) ? d_sub[W-1:0] : d[W-1:0];
    end

    assign last_iter = (it == IW'(NI - 1));
    assign last_step = (cnt == CW'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus busy/done strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = m[0] ? ST_INV_A : ST_DONE;
                end
            end
            ST_INV_A: state_nxt = ST_INV_B;
            ST_INV_B: state_nxt = last_iter ? ST_R2 : ST_INV_A;
            ST_R2:    state_nxt = last_step ? ST_DONE : ST_R2;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers and held results; results change only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            n_q    <= '0;
            x      <= '0;
            t      <= '0;
            v      <= '0;
            cnt    <= '0;
            it     <= '0;
            err    <= 1'b0;
            m_inv  <= '0;
            r2     <= '0;
            n_bits <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_q <= m;
                        n_q <= n_in;
                        if (!m[0]) begin
                            err    <= 1'b1;
                            m_inv  <= '0;
                            r2     <= '0;
                            n_bits <= n_in;
                        end else begin
                            // Any odd m is its own inverse mod 8: a 3-bit seed.
                            x   <= m;
                            it  <= '0;
                            v   <= (m == W'(1)) ? '0 : W'(1);
                            cnt <= {n_in, 1'b0};
                        end
                    end
                end
                ST_INV_A: begin
                    t <= prod;
                end
                ST_INV_B: begin
                    x  <= prod;
                    it <= it + IW'(1);
                end
                ST_R2: begin
                    v   <= v_nxt;
                    cnt <= cnt - CW'(1);
                    if (last_step) begin
                        m_inv  <= W'(0) - x;
                        r2     <= v_nxt;
                        n_bits <= n_q;
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mont_param_gen.md
Name: mont_param_gen

Overview:
- Upstream precompute stage for the Montgomery reduction datapath.
- Given an odd modulus m, it computes the three constants that stage consumes:
  - m_inv = -m^-1 mod 2^W, used in the "x*m_inv & (r-1)" step;
  - n = number of used bits of m (RIND);
  - r2 = R^2 mod m, with R = 2^n, used to convert operands into Montgomery form.
- Multi-cycle, one shared multiplier, start/done handshake; results are registered and held for the reduction block and the bus wrapper.

Parameters:
- W, 32, datapath width; must be a power of 2, 8 <= W <= 32.
- NI, $clog2(W)-1, Newton iterations; derived, not overridden (3*2^NI >= W).

Ports:
- clk     in   1      clock
- rst     in   1      reset
- start   in   1      request; sampled only when busy=0
- m       in   W      modulus
- busy    out  1      computation in progress
- done    out  1      one-cycle pulse, results valid
- err     out  1      m was even (includes 0); held with results
- m_inv   out  W      -m^-1 mod 2^W
- r2      out  W      2^(2n) mod m
- n_bits  out  6      used bits of m, 1..32

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset: state IDLE; busy, done, err = 0; m_inv, r2 = 0; n_bits = 0; all internal registers = 0.
- States: IDLE, INV_A, INV_B, R2, DONE.
- IDLE, start=1 at edge k:
  - latch m into m_q;
  - n_q = used bits of m (leading-one position + 1; 0 if m=0);
  - m even -> DONE with err=1, m_inv = r2 = 0, n_bits = n_q;
  - m odd -> INV_A with x = m (valid inverse mod 8), it = 0, v = (m==1) ? 0 : 1, cnt = 2*n_q.
- INV_A: t = low W bits of m_q*x. Go to INV_B.
- INV_B: x = low W bits of x*(2 - t), wrap mod 2^W; it++.
  - it == NI-1 before increment -> R2;
  - otherwise -> INV_A.
- R2: one doubling step per cycle, W+1-bit intermediate d = 2v; v = (d >= m_q) ? d - m_q : d; cnt--.
  - Leave for DONE on the step where cnt = 1.
  - Invariant: v < m_q always holds.
- DONE: lasts one cycle, then IDLE. Registers at DONE entry:
  - m_inv = -x (two's complement);
  - r2 = v;
  - n_bits = n_q;
  - err = 0 for odd m.
- busy = 1 in INV_A, INV_B, R2, DONE; busy = 0 in IDLE.
- done = 1 only in DONE.
- Latency: done is high after edge k + 2*NI + 2*n_q. For W=32 that is 8 + 2n, range 10..72. The even-m error path takes 1 edge.
- start while busy=1: ignored, with no effect on the operation in progress.
- start in the DONE cycle: ignored; it is accepted the following cycle in IDLE.
- m changing after the start edge: no effect (m_q is latched).
- Outputs hold their values until the next DONE; they are not cleared on a new start.
- rst mid-operation: immediate return to the reset values; no done pulse.

Decomposition:
- Shared package mont_pkg holds:
  - state enum (3-bit: IDLE=0, INV_A=1, INV_B=2, R2=3, DONE=4);
  - W default;
  - NI derivation function.
- One sub-module: mont_lead_one (combinational used-bits detector, W in, 6 out), also reusable by the reduction stage.
- Single W x W -> W (low half) multiplier, muxed between INV_A and INV_B.

Test Plan:
1. m=169 (0xA9), start pulse -> n_bits=8, r2=133, m_inv[7:0]=0x67, (169*m_inv+1) mod 2^32 = 0, err=0; done exactly 24 edges after the start edge.
2. m=3 -> n_bits=2, r2=1, m_inv=0x55555555, done at +12 edges; m=1 -> n_bits=1, r2=0, m_inv=0xFFFFFFFF, done at +10.
3. m=0xFFFFFFFF -> n_bits=32, r2=1, m_inv=0x00000001, done at +72; m=0x80000001 -> n_bits=32, r2 = golden model, done at +72.
4. m=170, then m=0 -> err=1, m_inv=0, r2=0, done 1 edge after start; n_bits=8 and 0 respectively.
5. Start m=169; at +5 pulse start with m=3 and change the m input -> the second start is ignored; results are those of 169 at +24; busy stays 1 throughout.
6. Start m=169; assert rst at +10 for 2 cycles -> all outputs 0, no done; then start m=3 -> correct result at +12; plus 1000 random odd m checked against a software model.
